// File: rtl/mult_sequencer.sv
`timescale 1ns/1ps
// mult_sequencer: shift-and-add unsigned N x N -> 2N multiplier sequencer.
// One adder step per cycle through an external N-bit adder.
// Timing: IDLE accepts start, then N RUN cycles, then one DONE cycle
// carrying the done pulse. Result stays on product until the next start.
module mult_sequencer #(
  parameter int N = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [N-1:0]   add_a,
  output logic [N-1:0]   add_b,
  output logic           add_sub,
  input  logic [N-1:0]   add_sum,
  input  logic           add_co,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_m;
  logic [N-1:0]  r_p_hi;
  logic [N-1:0]  r_p_lo;
  logic [CW-1:0] r_count;
  logic          r_busy;
  logic          r_done;

  logic          w_run;

  assign w_run = (r_state == S_RUN);

  // Adder operands: accumulator high half plus the multiplicand when the
  // current multiplier bit (P_lo[0]) is set; the adder is idle outside RUN.
  assign add_a   = w_run ? r_p_hi : '0;
  assign add_b   = (w_run && r_p_lo[0]) ? r_m : '0;
  assign add_sub = 1'b0;

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = {r_p_hi, r_p_lo};

  // Sequencer FSM: operand capture, one shift-add step per RUN cycle,
  // registered busy/done flags.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, matching the hardware it describes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_m     <= '0;
      r_p_hi  <= '0;
      r_p_lo  <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m     <= multiplicand;
            r_p_hi  <= '0;
            r_p_lo  <= multiplier;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // {P_hi, P_lo} <= {carry, sum, P_lo} >> 1
          r_p_hi <= {add_co, add_sum[N-1:1]};
          r_p_lo <= {add_sum[0], r_p_lo[N-1:1]};
          if (r_count == LAST) begin
            // Count stops at N-1 instead of wrapping on the final step.
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
`timescale 1ns/1ps
// tb_mult_sequencer: directed-vector bench for mult_sequencer (N = 64) with
// a behavioural model of the external ripple adder.
// Cycle numbering: start is raised just after edge E0, so it is accepted at
// E1; busy is expected after E1..EN and done only after E(N+1).
module tb_mult_sequencer;

  localparam int N = 64;

  logic           clk;
  logic           reset;
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic [N-1:0]   add_a;
  logic [N-1:0]   add_b;
  logic           add_sub;
  logic [N-1:0]   add_sum;
  logic           add_co;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int tests_run    = 0;
  int tests_failed = 0;

  mult_sequencer #(.N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_sub      (add_sub),
    .add_sum      (add_sum),
    .add_co       (add_co),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  // External N-bit adder: combinational sum and carry-out.
  logic [N:0] w_sum_full;
  assign w_sum_full = {1'b0, add_a} + {1'b0, add_b};
  assign add_sum    = w_sum_full[N-1:0];
  assign add_co     = w_sum_full[N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full multiply. Optionally re-asserts start with other operands
  // (2 x 2) for cycles noise_lo..noise_hi to show it is ignored.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [2*N-1:0] exp, input string name,
                        input int noise_lo, input int noise_hi);
    int busy_cnt;
    int done_cnt;
    int done_k;
    int bus_bad;
    busy_cnt = 0;
    done_cnt = 0;
    done_k   = -1;
    bus_bad  = 0;
    @(posedge clk); #1;
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    for (int k = 1; k <= N + 3; k++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (add_sub !== 1'b0) bus_bad++;
      if (!busy && (add_a !== '0 || add_b !== '0)) bus_bad++;
      if (done) begin
        done_cnt++;
        done_k = k;
        tests_run++;
        if (product !== exp) begin
          tests_failed++;
          $display("FAIL %s product at done: got %h expected %h", name, product, exp);
        end
      end
      start = (k >= noise_lo && k <= noise_hi);
      if (start) begin
        multiplicand = 64'd2;
        multiplier   = 64'd2;
      end else begin
        multiplicand = {$urandom(), $urandom()};
        multiplier   = {$urandom(), $urandom()};
      end
    end
    tests_run++;
    if (busy_cnt !== N) begin
      tests_failed++;
      $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_cnt, N);
    end
    tests_run++;
    if (done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL %s done pulses: got %0d expected 1", name, done_cnt);
    end
    tests_run++;
    if (done_k !== N + 1) begin
      tests_failed++;
      $display("FAIL %s done cycle: got %0d expected %0d", name, done_k, N + 1);
    end
    tests_run++;
    if (bus_bad !== 0) begin
      tests_failed++;
      $display("FAIL %s adder bus outside RUN: got %0d bad cycles expected 0", name, bus_bad);
    end
    tests_run++;
    if (product !== exp) begin
      tests_failed++;
      $display("FAIL %s product held in IDLE: got %h expected %h", name, product, exp);
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    #2;
    tests_run++;
    if ({busy, done, add_sub} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset flags: got busy=%b done=%b add_sub=%b expected 0 0 0", busy, done, add_sub);
    end
    tests_run++;
    if (product !== '0) begin
      tests_failed++;
      $display("FAIL reset product: got %h expected 0", product);
    end
    tests_run++;
    if (add_a !== '0 || add_b !== '0) begin
      tests_failed++;
      $display("FAIL reset adder bus: got a=%h b=%h expected 0 0", add_a, add_b);
    end
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset start ignored: got busy=%b expected 0", busy);
    end
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    run_op(64'd3, 64'd5, 128'd15, "basic_3x5", 0, -1);
  endtask

  task automatic test_max();
    run_op('1, '1, {64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001}, "max_operands", 0, -1);
  endtask

  task automatic test_zero();
    run_op(64'd0, 64'h1234, 128'd0, "zero_a", 0, -1);
  endtask

  task automatic test_boundaries();
    run_op(64'h8000_0000_0000_0000, 64'd2, {64'd1, 64'd0}, "carry_into_high", 0, -1);
    run_op(64'd1, '1, {64'd0, 64'hFFFF_FFFF_FFFF_FFFF}, "one_times_max", 0, -1);
  endtask

  task automatic test_start_ignored();
    run_op(64'd7, 64'd9, 128'd63, "start_in_run", 5, N + 1);
  endtask

  task automatic test_reset_abort();
    int done_cnt;
    int busy_cnt;
    done_cnt = 0;
    busy_cnt = 0;
    @(posedge clk); #1;
    start        = 1'b1;
    multiplicand = 64'd5;
    multiplier   = 64'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort busy before reset: got %b expected 1", busy);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort flags: got busy=%b done=%b expected 0 0", busy, done);
    end
    tests_run++;
    if (product !== '0) begin
      tests_failed++;
      $display("FAIL abort product: got %h expected 0", product);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < N + 3; k++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    tests_run++;
    if (done_cnt !== 0 || busy_cnt !== 0) begin
      tests_failed++;
      $display("FAIL abort aftermath: got done=%0d busy=%0d cycles expected 0 0", done_cnt, busy_cnt);
    end
    run_op(64'd6, 64'd7, 128'd42, "after_abort_6x7", 0, -1);
  endtask

  task automatic test_back_to_back();
    int dk[3];
    int done_cnt;
    int busy_cnt;
    int prod_bad;
    done_cnt = 0;
    busy_cnt = 0;
    prod_bad = 0;
    dk = '{-1, -1, -1};
    @(posedge clk); #1;
    start        = 1'b1;
    multiplicand = 64'd2;
    multiplier   = 64'd3;
    for (int k = 1; k <= 3 * N + 5; k++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (done) begin
        if (done_cnt < 3) dk[done_cnt] = k;
        done_cnt++;
        if (product !== 128'd6) prod_bad++;
      end
    end
    start = 1'b0;
    tests_run++;
    if (done_cnt !== 3) begin
      tests_failed++;
      $display("FAIL b2b done count: got %0d expected 3", done_cnt);
    end
    tests_run++;
    if (dk[0] !== N + 1 || dk[1] !== 2 * N + 3 || dk[2] !== 3 * N + 5) begin
      tests_failed++;
      $display("FAIL b2b done cycles: got %0d %0d %0d expected %0d %0d %0d",
               dk[0], dk[1], dk[2], N + 1, 2 * N + 3, 3 * N + 5);
    end
    tests_run++;
    if (busy_cnt !== 3 * N) begin
      tests_failed++;
      $display("FAIL b2b busy cycles: got %0d expected %0d", busy_cnt, 3 * N);
    end
    tests_run++;
    if (prod_bad !== 0) begin
      tests_failed++;
      $display("FAIL b2b product: got %0d wrong results expected 0", prod_bad);
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || product !== 128'd6) begin
      tests_failed++;
      $display("FAIL b2b idle after release: got busy=%b product=%h expected 0 6", busy, product);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_boundaries();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
